// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 decode/ID-EX slice: opcodes, ALU encodings
// and the control bundle produced by the instruction decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // uses_rs2 feeds only the load-use check; it is not carried into EX
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       uses_rs2;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV64 subset decoder: register fields, control bundle,
// sign-extended immediate and a legal flag (illegal encodings give all-zero control).
module instr_decoder
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_legal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_legal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign o_rd     = i_instr[11:7];

  assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};

  always_comb begin
    w_ctrl  = '0;
    w_imm   = '0;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.uses_rs2  = 1'b1;
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == 7'b0000000) begin
              w_ctrl.alu_op = ALU_ADD;
              w_legal       = 1'b1;
            end else if (w_funct7 == 7'b0100000) begin
              w_ctrl.alu_op = ALU_SUB;
              w_legal       = 1'b1;
            end
          end
          3'b111: begin
            w_ctrl.alu_op = ALU_AND;
            w_legal       = 1'b1;
          end
          3'b110: begin
            w_ctrl.alu_op = ALU_OR;
            w_legal       = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_ITYPE: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm            = w_imm_i;
        case (w_funct3)
          3'b000: begin
            w_ctrl.alu_op = ALU_ADD;
            w_legal       = 1'b1;
          end
          3'b111: begin
            w_ctrl.alu_op = ALU_AND;
            w_legal       = 1'b1;
          end
          3'b110: begin
            w_ctrl.alu_op = ALU_OR;
            w_legal       = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        if (w_funct3 == 3'b011) begin
          w_ctrl.alu_op     = ALU_ADD;
          w_ctrl.alu_src    = 1'b1;
          w_ctrl.mem_read   = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
          w_ctrl.reg_write  = 1'b1;
          w_imm             = w_imm_i;
          w_legal           = 1'b1;
        end
      end
      OPC_STORE: begin
        if (w_funct3 == 3'b011) begin
          w_ctrl.alu_op    = ALU_ADD;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.mem_write = 1'b1;
          w_ctrl.uses_rs2  = 1'b1;
          w_imm            = w_imm_s;
          w_legal          = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (w_funct3 == 3'b000) begin
          w_ctrl.alu_op   = ALU_SUB;
          w_ctrl.branch   = 1'b1;
          w_ctrl.uses_rs2 = 1'b1;
          w_imm           = w_imm_b;
          w_legal         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_ctrl  = w_legal ? w_ctrl : '0;
  assign o_imm   = w_imm;
  assign o_legal = w_legal;

endmodule

// File: rtl/id_ex_stage.sv
// Decode and ID/EX pipeline register: write-back bypass into the operands,
// load-use stall detection and branch flush.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int WB_BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_id_valid,
  input  logic [31:0]     i_id_instr,
  input  logic [XLEN-1:0] i_id_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs1_data,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_rs1,
  output logic [4:0]      o_ex_rs2,
  output logic [4:0]      o_ex_rd,
  output logic [3:0]      o_ex_alu_op,
  output logic            o_ex_alu_src,
  output logic            o_ex_mem_read,
  output logic            o_ex_mem_write,
  output logic            o_ex_reg_write,
  output logic            o_ex_mem_to_reg,
  output logic            o_ex_branch
);

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_legal;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_stall;
  logic            w_capture;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [3:0]      r_alu_op;
  logic            r_alu_src;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_reg_write;
  logic            r_mem_to_reg;
  logic            r_branch;

  instr_decoder #(.XLEN(XLEN)) u_decoder (
    .i_instr (i_id_instr),
    .o_rs1   (w_rs1),
    .o_rs2   (w_rs2),
    .o_rd    (w_rd),
    .o_ctrl  (w_ctrl),
    .o_imm   (w_imm),
    .o_legal (w_legal)
  );

  assign o_rs1 = w_rs1;
  assign o_rs2 = w_rs2;
  assign o_rd  = w_rd;

  // The register file writes on the same edge we capture, so its read is stale
  assign w_byp1 = (WB_BYPASS != 0) && i_wb_reg_write && (i_wb_rd == w_rs1) && (w_rs1 != 5'd0);
  assign w_byp2 = (WB_BYPASS != 0) && i_wb_reg_write && (i_wb_rd == w_rs2) && (w_rs2 != 5'd0);
  assign w_op1  = w_byp1 ? i_wb_data : i_rs1_data;
  assign w_op2  = w_byp2 ? i_wb_data : i_rs2_data;

  assign w_hit1    = w_legal && (r_rd == w_rs1);
  assign w_hit2    = w_legal && w_ctrl.uses_rs2 && (r_rd == w_rs2);
  assign w_stall   = !i_reset && r_valid && r_mem_read && (r_rd != 5'd0) &&
                     (w_hit1 || w_hit2) && i_id_valid && !i_flush;
  assign w_capture = i_id_valid && w_legal && !i_flush && !w_stall;
  assign o_stall   = w_stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || !w_capture) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_pc         <= i_id_pc;
      r_rs1_data   <= w_op1;
      r_rs2_data   <= w_op2;
      r_imm        <= w_imm;
      r_rs1        <= w_rs1;
      r_rs2        <= w_rs2;
      r_rd         <= w_rd;
      r_alu_op     <= w_ctrl.alu_op;
      r_alu_src    <= w_ctrl.alu_src;
      r_mem_read   <= w_ctrl.mem_read;
      r_mem_write  <= w_ctrl.mem_write;
      r_reg_write  <= w_ctrl.reg_write;
      r_mem_to_reg <= w_ctrl.mem_to_reg;
      r_branch     <= w_ctrl.branch;
    end
  end

  assign o_ex_valid      = r_valid;
  assign o_ex_pc         = r_pc;
  assign o_ex_rs1_data   = r_rs1_data;
  assign o_ex_rs2_data   = r_rs2_data;
  assign o_ex_imm        = r_imm;
  assign o_ex_rs1        = r_rs1;
  assign o_ex_rs2        = r_rs2;
  assign o_ex_rd         = r_rd;
  assign o_ex_alu_op     = r_alu_op;
  assign o_ex_alu_src    = r_alu_src;
  assign o_ex_mem_read   = r_mem_read;
  assign o_ex_mem_write  = r_mem_write;
  assign o_ex_reg_write  = r_reg_write;
  assign o_ex_mem_to_reg = r_mem_to_reg;
  assign o_ex_branch     = r_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push hand-computed
// EX contents into a queue that a posedge monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  aluOp;
    logic [5:0]  ctl;   // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
  } exp_t;

  localparam exp_t BUBBLE = '0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        idValid = 1'b0;
  logic [31:0] idInstr = '0;
  logic [63:0] idPc = '0;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] rs1Data = '0, rs2Data = '0;
  logic        wbRegWrite = 1'b0;
  logic [4:0]  wbRd = '0;
  logic [63:0] wbData = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        exValid;
  logic [63:0] exPc, exRs1Data, exRs2Data, exImm;
  logic [4:0]  exRs1, exRs2, exRd;
  logic [3:0]  exAluOp;
  logic        exAluSrc, exMemRead, exMemWrite, exRegWrite, exMemToReg, exBranch;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .WB_BYPASS(1)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_id_valid      (idValid),
    .i_id_instr      (idInstr),
    .i_id_pc         (idPc),
    .o_rs1           (rs1),
    .o_rs2           (rs2),
    .o_rd            (rd),
    .i_rs1_data      (rs1Data),
    .i_rs2_data      (rs2Data),
    .i_wb_reg_write  (wbRegWrite),
    .i_wb_rd         (wbRd),
    .i_wb_data       (wbData),
    .i_flush         (flush),
    .o_stall         (stall),
    .o_ex_valid      (exValid),
    .o_ex_pc         (exPc),
    .o_ex_rs1_data   (exRs1Data),
    .o_ex_rs2_data   (exRs2Data),
    .o_ex_imm        (exImm),
    .o_ex_rs1        (exRs1),
    .o_ex_rs2        (exRs2),
    .o_ex_rd         (exRd),
    .o_ex_alu_op     (exAluOp),
    .o_ex_alu_src    (exAluSrc),
    .o_ex_mem_read   (exMemRead),
    .o_ex_mem_write  (exMemWrite),
    .o_ex_reg_write  (exRegWrite),
    .o_ex_mem_to_reg (exMemToReg),
    .o_ex_branch     (exBranch)
  );

  function automatic exp_t mkExp(input logic v, input logic [63:0] pc, input logic [63:0] r1d,
                                 input logic [63:0] r2d, input logic [63:0] imm,
                                 input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                 input logic [3:0] op, input logic [5:0] ctl);
    exp_t e;
    e.valid = v;  e.pc = pc;  e.rs1d = r1d;  e.rs2d = r2d;  e.imm = imm;
    e.rs1 = a;    e.rs2 = b;  e.rd = d;      e.aluOp = op;  e.ctl = ctl;
    return e;
  endfunction

  function automatic exp_t actual();
    return mkExp(exValid, exPc, exRs1Data, exRs2Data, exImm, exRs1, exRs2, exRd, exAluOp,
                 {exAluSrc, exMemRead, exMemWrite, exRegWrite, exMemToReg, exBranch});
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL %s: got v=%0b pc=%h r1d=%h r2d=%h imm=%h rs=%0d/%0d/%0d op=%b ctl=%b, expected v=%0b pc=%h r1d=%h r2d=%h imm=%h rs=%0d/%0d/%0d op=%b ctl=%b",
               name, a.valid, a.pc, a.rs1d, a.rs2d, a.imm, a.rs1, a.rs2, a.rd, a.aluOp, a.ctl,
               e.valid, e.pc, e.rs1d, e.rs2d, e.imm, e.rs1, e.rs2, e.rd, e.aluOp, e.ctl);
    end
  endtask

  // One cycle of ID input; stall is checked combinationally, EX result queued
  task automatic applyStimulus(input string name, input logic [31:0] instr, input logic [63:0] pc,
                               input logic [63:0] r1d, input logic [63:0] r2d,
                               input logic wbw, input logic [4:0] wbr, input logic [63:0] wbd,
                               input logic fl, input logic v, input logic expStall, input exp_t e);
    @(negedge clk);
    idInstr = instr;  idPc = pc;  rs1Data = r1d;  rs2Data = r2d;
    wbRegWrite = wbw; wbRd = wbr; wbData = wbd;   flush = fl;  idValid = v;
    #1;
    checks++;
    if (stall !== expStall) begin
      failures++;
      $display("[TB] FAIL %s stall: got %0b expected %0b", name, stall, expStall);
    end
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkReset(input string name);
    exp_t a;
    a = actual();
    checks++;
    if (a !== BUBBLE || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s: got v=%0b pc=%h rd=%0d ctl=%b stall=%0b, expected all zero",
               name, a.valid, a.pc, a.rd, a.ctl, stall);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(n, e);
    end
  end

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, SUB_ = 4'b0110;
  localparam logic [5:0] C_R = 6'b000100, C_I = 6'b100100, C_LD = 6'b110110,
                         C_SD = 6'b101000, C_BR = 6'b000001;

  initial begin
    #1 reset = 1'b1;
    #2 checkReset("power-on reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("add x3,x1,x2", 32'h002081B3, 64'h100, 64'd1, 64'd2, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h100, 64'd1, 64'd2, 64'd0, 1, 2, 3, ADD_, C_R));

    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkReset("async reset mid-operation");
    idValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("addi x7,x0,-1 (x0 no bypass)", 32'hFFF00393, 64'h104, 64'd0, 64'h99, 1, 0, 64'hAA, 0, 1, 0,
                  mkExp(1, 64'h104, 64'd0, 64'h99, 64'hFFFFFFFFFFFFFFFF, 0, 31, 7, ADD_, C_I));
    applyStimulus("ld x5,8(x2)", 32'h00813283, 64'h108, 64'h1000, 64'h22, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h108, 64'h1000, 64'h22, 64'd8, 2, 8, 5, ADD_, C_LD));
    applyStimulus("load-use add stalled", 32'h00128333, 64'h10C, 64'h50, 64'h10, 0, 0, 0, 0, 1, 1, BUBBLE);
    applyStimulus("load-use add replay", 32'h00128333, 64'h10C, 64'h50, 64'h10, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h10C, 64'h50, 64'h10, 64'd0, 5, 1, 6, ADD_, C_R));
    applyStimulus("bypass rs1 wb_rd=1", 32'h002081B3, 64'h110, 64'd1, 64'd2, 1, 1, 64'h55, 0, 1, 0,
                  mkExp(1, 64'h110, 64'h55, 64'd2, 64'd0, 1, 2, 3, ADD_, C_R));
    applyStimulus("no bypass wb_rd=0", 32'h002081B3, 64'h110, 64'd1, 64'd2, 1, 0, 64'h55, 0, 1, 0,
                  mkExp(1, 64'h110, 64'd1, 64'd2, 64'd0, 1, 2, 3, ADD_, C_R));
    applyStimulus("bypass rs2 wb_rd=2", 32'h002081B3, 64'h110, 64'd1, 64'd2, 1, 2, 64'h77, 0, 1, 0,
                  mkExp(1, 64'h110, 64'd1, 64'h77, 64'd0, 1, 2, 3, ADD_, C_R));
    applyStimulus("ld x5 before ori", 32'h00813283, 64'h114, 64'h1000, 64'h22, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h114, 64'h1000, 64'h22, 64'd8, 2, 8, 5, ADD_, C_LD));
    applyStimulus("ori rs2 field unused", 32'h0050E413, 64'h118, 64'd3, 64'd4, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h118, 64'd3, 64'd4, 64'd5, 1, 5, 8, OR_, C_I));
    applyStimulus("ld x5 before beq", 32'h00813283, 64'h11C, 64'h1000, 64'h22, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h11C, 64'h1000, 64'h22, 64'd8, 2, 8, 5, ADD_, C_LD));
    applyStimulus("beq rs2 load-use stalled", 32'hFE508EE3, 64'h120, 64'd7, 64'd7, 0, 0, 0, 0, 1, 1, BUBBLE);
    applyStimulus("beq replay", 32'hFE508EE3, 64'h120, 64'd7, 64'd7, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h120, 64'd7, 64'd7, 64'hFFFFFFFFFFFFFFFC, 1, 5, 29, SUB_, C_BR));
    applyStimulus("ld x5 before flush", 32'h00813283, 64'h124, 64'h1000, 64'h22, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h124, 64'h1000, 64'h22, 64'd8, 2, 8, 5, ADD_, C_LD));
    applyStimulus("flush beats stall", 32'h00128333, 64'h128, 64'h50, 64'h10, 0, 0, 0, 1, 1, 0, BUBBLE);
    applyStimulus("ld x0", 32'h00813003, 64'h12C, 64'h1000, 64'h22, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h12C, 64'h1000, 64'h22, 64'd8, 2, 8, 0, ADD_, C_LD));
    applyStimulus("add x6,x0,x1 no x0 hazard", 32'h00100333, 64'h130, 64'd0, 64'd9, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h130, 64'd0, 64'd9, 64'd0, 0, 1, 6, ADD_, C_R));
    applyStimulus("sd x5,-8(x1)", 32'hFE50BC23, 64'h134, 64'h2000, 64'd5, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h134, 64'h2000, 64'd5, 64'hFFFFFFFFFFFFFFF8, 1, 5, 24, ADD_, C_SD));
    applyStimulus("sub x9,x5,x6", 32'h406284B3, 64'h138, 64'd10, 64'd3, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h138, 64'd10, 64'd3, 64'd0, 5, 6, 9, SUB_, C_R));
    applyStimulus("and x10,x1,x2", 32'h0020F533, 64'h13C, 64'hF0, 64'h3C, 0, 0, 0, 0, 1, 0,
                  mkExp(1, 64'h13C, 64'hF0, 64'h3C, 64'd0, 1, 2, 10, AND_, C_R));
    applyStimulus("illegal opcode", 32'h0000007F, 64'h140, 64'd1, 64'd2, 0, 0, 0, 0, 1, 0, BUBBLE);
    applyStimulus("illegal funct7", 32'h022081B3, 64'h144, 64'd1, 64'd2, 0, 0, 0, 0, 1, 0, BUBBLE);
    applyStimulus("id_valid low", 32'h002081B3, 64'h148, 64'd1, 64'd2, 0, 0, 0, 0, 0, 0, BUBBLE);

    @(negedge clk);
    idValid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
